// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller in front of the processor's irq/eoi lines.
// Synchronises up to 32 raw sources, latches them as pending (edge or level
// mode per source), picks one enabled pending source and runs the irq/eoi
// handshake on line 0. PENDING/ENABLE/EDGE/ACTIVE are reachable over the
// sel/ack slave bus.
//
// Optional feature: define IRQ_CTRL_ROUND_ROBIN_EN to replace fixed
// lowest-index priority with round-robin selection starting after the
// most recently serviced source.
//
// Bus handshake: a transfer starts whenever sel_i=1 and ack_o=0; ack_o is
// raised for exactly one cycle on the following edge, with read data valid
// in data_o for that cycle and write data committed on that same edge.
// A master that keeps sel_i high across the ack cycle does not get a
// second ack, because the ack cycle itself blocks a new start.
//
// Interrupt handshake: irq_o[0] is high only in REQ. The processor holds
// eoi_i[0] high while idle, pulls it low to accept, and raises it again
// at end of interrupt.

module irq_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_ni,
    input  logic [NUM_SRC-1:0] src_i,
    output logic [31:0]        irq_o,
    input  logic [31:0]        eoi_i,
    input  logic               sel_i,
    input  logic [3:0]         addr_i,
    input  logic               we_i,
    input  logic [3:0]         wr_mask_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic               ack_o,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;
    localparam logic [1:0] GAP     = 2'd3;

    // Bits at or above NUM_SRC are forced to zero in every register.
    localparam logic [31:0] SRC_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                     : ((32'd1 << NUM_SRC) - 32'd1);

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [31:0]        s_now;
    logic [31:0]        s_d;
    logic [31:0]        rise;

    logic [31:0] pending_q;
    logic [31:0] enable_q;
    logic [31:0] edge_q;
    logic [31:0] pending_next;
    logic [31:0] req_vec;
    logic [31:0] w1c;
    logic [31:0] svc_clr;
    logic [31:0] byte_mask;
    logic [31:0] rdata;
    logic [31:0] active;

    logic [1:0]  state;
    logic [4:0]  id;
    logic [4:0]  sel_id;
    logic        accept;

    logic        bus_go;
    logic        wr_go;
    logic        rd_go;
    logic [1:0]  word;

    logic        unused_bits;

    assign unused_bits = ^{eoi_i[31:1], addr_i[1:0]};

    assign bus_go    = sel_i & ~ack_o;
    assign wr_go     = bus_go & we_i;
    assign rd_go     = bus_go & ~we_i;
    assign word      = addr_i[3:2];
    assign byte_mask = {{8{wr_mask_i[3]}}, {8{wr_mask_i[2]}},
                        {8{wr_mask_i[1]}}, {8{wr_mask_i[0]}}};

    assign accept    = (state == REQ) && !eoi_i[0];
    assign req_vec   = pending_q & enable_q;
    assign irq_o     = {31'd0, state == REQ};
    assign dbg_state = state;

    // Synchroniser chain for the raw asynchronous sources.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= src_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Widen the synchronised sources to the 32-bit register layout.
    always_comb begin
        s_now = '0;
        s_now[NUM_SRC-1:0] = sync_q[SYNC_STAGES-1];
    end

    // Delayed copy of the synchronised sources for rising-edge detection.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            s_d <= '0;
        end else begin
            s_d <= s_now;
        end
    end

    assign rise = s_now & ~s_d;
    assign w1c  = (wr_go && word == 2'd0) ? (data_i & byte_mask & SRC_MASK) : '0;

    // One-hot clear of the accepted source, applied on SERVICE entry.
    always_comb begin
        svc_clr = '0;
        if (accept) begin
            svc_clr[id] = 1'b1;
        end
    end

    // Edge-mode bits: a new rising edge beats any clear in the same cycle.
    // Level-mode bits simply track the synchronised input.
    assign pending_next = ((edge_q & ((pending_q & ~w1c & ~svc_clr) | rise))
                          | (~edge_q & s_now)) & SRC_MASK;

    // PENDING, ENABLE and EDGE register updates.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
        end else begin
            pending_q <= pending_next;
            if (wr_go && word == 2'd1) begin
                enable_q <= ((enable_q & ~byte_mask) | (data_i & byte_mask)) & SRC_MASK;
            end
            if (wr_go && word == 2'd2) begin
                edge_q <= ((edge_q & ~byte_mask) | (data_i & byte_mask)) & SRC_MASK;
            end
        end
    end

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [4:0] last_id;
    logic [5:0] rr_idx;
    logic       rr_found;

    // Remember the most recently accepted source as the round-robin origin.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            last_id <= '0;
        end else if (accept) begin
            last_id <= id;
        end
    end

    // Round-robin pick: first request searching upward from last_id+1, wrapping.
    always_comb begin
        sel_id   = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            rr_idx = 6'(last_id) + 6'(k);
            if (rr_idx >= 6'(NUM_SRC)) begin
                rr_idx = rr_idx - 6'(NUM_SRC);
            end
            if (!rr_found && req_vec[rr_idx[4:0]]) begin
                rr_found = 1'b1;
                sel_id   = rr_idx[4:0];
            end
        end
    end
`else
    // Fixed priority pick: the lowest requesting index wins.
    always_comb begin
        sel_id = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req_vec[k]) begin
                sel_id = 5'(k);
            end
        end
    end
`endif

    // Request FSM driving the irq/eoi handshake on line 0.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
            id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        id    <= sel_id;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!eoi_i[0]) begin
                        state <= SERVICE;
                    end else if (!req_vec[id]) begin
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (eoi_i[0]) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign active = {(state != IDLE), 26'd0, ((state != IDLE) ? id : 5'd0)};

    // Read multiplexer over the four register words.
    always_comb begin
        rdata = '0;
        case (word)
            2'd0: rdata = pending_q;
            2'd1: rdata = enable_q;
            2'd2: rdata = edge_q;
            2'd3: rdata = active;
            default: rdata = '0;
        endcase
    end

    // Bus acknowledge and registered read data.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            ack_o  <= bus_go;
            data_o <= rd_go ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl: reset, bus registers, edge handshake,
// level withdraw, reset during REQ, priority order and W1C race.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_irq_ctrl;

    localparam int NUM_SRC = 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    localparam logic [3:0] A_PEND = 4'h0;
    localparam logic [3:0] A_EN   = 4'h4;
    localparam logic [3:0] A_EDGE = 4'h8;
    localparam logic [3:0] A_ACT  = 4'hC;

    logic               clk = 1'b0;
    logic               reset_ni;
    logic [NUM_SRC-1:0] src_i;
    logic [31:0]        irq_o;
    logic [31:0]        eoi_i;
    logic               sel_i;
    logic [3:0]         addr_i;
    logic               we_i;
    logic [3:0]         wr_mask_i;
    logic [31:0]        data_i;
    logic [31:0]        data_o;
    logic               ack_o;
    logic [1:0]         dbg_state;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_ni  (reset_ni),
        .src_i     (src_i),
        .irq_o     (irq_o),
        .eoi_i     (eoi_i),
        .sel_i     (sel_i),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .wr_mask_i (wr_mask_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .ack_o     (ack_o),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks (called at a falling edge) ----------------

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] mask);
        sel_i = 1'b1; we_i = 1'b1; addr_i = addr; data_i = data; wr_mask_i = mask;
        @(negedge clk);
        sel_i = 1'b0; we_i = 1'b0; wr_mask_i = 4'h0; data_i = '0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        sel_i = 1'b1; we_i = 1'b0; addr_i = addr;
        @(negedge clk);
        data = data_o;
        sel_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic serve();
        eoi_i = 32'h0;
        @(negedge clk);
        eoi_i = 32'h1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_irq(input logic lvl, output int waited);
        waited = -1;
        for (int i = 0; i < 20; i++) begin
            if (irq_o[0] === lvl) begin
                waited = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        logic [31:0] rd;
        reset_ni = 1'b0;
        src_i = '0; eoi_i = 32'h1; sel_i = 1'b0; addr_i = '0; we_i = 1'b0;
        wr_mask_i = '0; data_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL reset_irq: got %h want %h", irq_o, 32'h0); end
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
        reset_ni = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            bus_read(4'(a * 4), rd);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", a, rd); end
        end
    endtask

    task automatic test_bus();
        logic [31:0] rd;
        int          acks;
        bus_write(A_EN, 32'hFFFF_FFFF, 4'b0001);
        bus_read(A_EN, rd);
        checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL en_mask0001: got %h want %h", rd, 32'hFF); end
        bus_write(A_EN, 32'h0000_0000, 4'b1110);
        bus_read(A_EN, rd);
        checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL en_mask1110: got %h want %h", rd, 32'hFF); end
        bus_write(A_EN, 32'h0000_0000, 4'b1111);
        bus_write(A_EN, 32'hFFFF_FFFF, 4'b1111);
        bus_read(A_EN, rd);
        checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL en_unmapped: got %h want %h", rd, 32'hFF); end
        bus_write(A_EDGE, 32'h1234_5678, 4'b0001);
        bus_read(A_EDGE, rd);
        checks++; if (rd !== 32'h0000_0078) begin errors++; $display("FAIL edge_rw: got %h want %h", rd, 32'h78); end
        bus_write(A_ACT, 32'hFFFF_FFFF, 4'b1111);
        bus_read(A_ACT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL act_ro: got %h want 0", rd); end
        bus_write(A_EN, 32'h0, 4'b1111);
        bus_write(A_EDGE, 32'h0, 4'b1111);
        bus_read(A_EN, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL en_clear: got %h want 0", rd); end
        // Hold sel for two cycles: only the first cycle may ack.
        acks = 0;
        sel_i = 1'b1; we_i = 1'b0; addr_i = A_PEND;
        @(negedge clk);
        if (ack_o === 1'b1) acks++;
        @(negedge clk);
        if (ack_o === 1'b1) acks++;
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL data_idle: got %h want 0", data_o); end
        sel_i = 1'b0;
        @(negedge clk);
        if (ack_o === 1'b1) acks++;
        checks++; if (acks != 1) begin errors++; $display("FAIL ack_once: got %0d acks want 1", acks); end
    endtask

    task automatic test_edge_handshake();
        logic [31:0] rd;
        bus_write(A_EDGE, 32'h04, 4'b1111);
        bus_write(A_EN, 32'h04, 4'b1111);
        src_i = 8'h04;
        @(negedge clk);
        src_i = 8'h00;
        @(negedge clk);
        checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL edge_early2: got %h want 0", irq_o); end
        @(negedge clk);
        checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL edge_early3: got %h want 0", irq_o); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h04) begin errors++; $display("FAIL edge_pending: got %h want %h", rd, 32'h04); end
        checks++; if (irq_o !== 32'h1) begin errors++; $display("FAIL edge_irq: got %h want %h", irq_o, 32'h1); end
        eoi_i = 32'h0;
        @(negedge clk);
        checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL edge_irq_drop: got %h want 0", irq_o); end
        checks++; if (dbg_state !== S_SERVICE) begin errors++; $display("FAIL edge_service: got %0d want %0d", dbg_state, S_SERVICE); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_pend_clr: got %h want 0", rd); end
        bus_read(A_ACT, rd);
        checks++; if (rd !== 32'h8000_0002) begin errors++; $display("FAIL edge_active: got %h want %h", rd, 32'h8000_0002); end
        eoi_i = 32'h1;
        @(negedge clk);
        checks++; if (dbg_state !== S_GAP) begin errors++; $display("FAIL edge_gap: got %0d want %0d", dbg_state, S_GAP); end
        checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL edge_gap_irq: got %h want 0", irq_o); end
        @(negedge clk);
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL edge_idle: got %0d want %0d", dbg_state, S_IDLE); end
        bus_read(A_ACT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_act_idle: got %h want 0", rd); end
    endtask

    task automatic test_level_withdraw();
        logic [31:0] rd;
        bus_write(A_EDGE, 32'h0, 4'b1111);
        bus_write(A_EN, 32'h01, 4'b1111);
        src_i = 8'h01;
        repeat (3) @(negedge clk);
        checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL lvl_early: got %h want 0", irq_o); end
        @(negedge clk);
        checks++; if (irq_o !== 32'h1) begin errors++; $display("FAIL lvl_irq: got %h want %h", irq_o, 32'h1); end
        src_i = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (irq_o !== 32'h1) begin errors++; $display("FAIL lvl_hold: got %h want %h", irq_o, 32'h1); end
        @(negedge clk);
        checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL lvl_withdraw: got %h want 0", irq_o); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL lvl_idle: got %0d want %0d", dbg_state, S_IDLE); end
        bus_read(A_ACT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lvl_active: got %h want 0", rd); end
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] rd;
        int          waited;
        src_i = 8'h01;
        wait_irq(1'b1, waited);
        checks++; if (waited < 0) begin errors++; $display("FAIL rst_req_timeout: irq never rose, want rise within 20 cycles"); end
        checks++; if (dbg_state !== S_REQ) begin errors++; $display("FAIL rst_in_req: got %0d want %0d", dbg_state, S_REQ); end
        reset_ni = 1'b0;
        #1;
        checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL rst_async_irq: got %h want 0", irq_o); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_async_state: got %0d want %0d", dbg_state, S_IDLE); end
        src_i = 8'h00;
        @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            bus_read(4'(a * 4), rd);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_reg%0d: got %h want 0", a, rd); end
        end
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        logic [31:0] exp_first;
        logic [31:0] exp_second;
        int          waited;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
        exp_first  = 32'h8000_0006;
        exp_second = 32'h8000_0001;
`else
        exp_first  = 32'h8000_0001;
        exp_second = 32'h8000_0006;
`endif
        bus_write(A_EDGE, 32'h62, 4'b1111);
        bus_write(A_EN, 32'h62, 4'b1111);
        src_i = 8'h22;
        @(negedge clk);
        src_i = 8'h00;
        wait_irq(1'b1, waited);
        checks++; if (waited < 0) begin errors++; $display("FAIL prio_irq1: timeout, want irq within 20 cycles"); end
        bus_read(A_ACT, rd);
        checks++; if (rd !== 32'h8000_0001) begin errors++; $display("FAIL prio_first: got %h want %h", rd, 32'h8000_0001); end
        serve();
        wait_irq(1'b1, waited);
        checks++; if (waited < 0) begin errors++; $display("FAIL prio_irq5: timeout, want irq within 20 cycles"); end
        bus_read(A_ACT, rd);
        checks++; if (rd !== 32'h8000_0005) begin errors++; $display("FAIL prio_second: got %h want %h", rd, 32'h8000_0005); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h20) begin errors++; $display("FAIL prio_pend5: got %h want %h", rd, 32'h20); end
        eoi_i = 32'h0;
        @(negedge clk);
        checks++; if (dbg_state !== S_SERVICE) begin errors++; $display("FAIL prio_svc5: got %0d want %0d", dbg_state, S_SERVICE); end
        src_i = 8'h42;
        @(negedge clk);
        src_i = 8'h00;
        repeat (2) @(negedge clk);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h42) begin errors++; $display("FAIL prio_pend16: got %h want %h", rd, 32'h42); end
        eoi_i = 32'h1;
        wait_irq(1'b1, waited);
        checks++; if (waited < 0) begin errors++; $display("FAIL prio_irq3: timeout, want irq within 20 cycles"); end
        bus_read(A_ACT, rd);
        checks++; if (rd !== exp_first) begin errors++; $display("FAIL prio_third: got %h want %h", rd, exp_first); end
        serve();
        wait_irq(1'b1, waited);
        checks++; if (waited < 0) begin errors++; $display("FAIL prio_irq4: timeout, want irq within 20 cycles"); end
        bus_read(A_ACT, rd);
        checks++; if (rd !== exp_second) begin errors++; $display("FAIL prio_fourth: got %h want %h", rd, exp_second); end
        serve();
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL prio_drained: got %h want 0", rd); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL prio_idle: got %0d want %0d", dbg_state, S_IDLE); end
        bus_write(A_EN, 32'h0, 4'b1111);
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd;
        bus_write(A_EDGE, 32'h08, 4'b1111);
        src_i = 8'h08;
        @(negedge clk);
        src_i = 8'h00;
        repeat (2) @(negedge clk);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h08) begin errors++; $display("FAIL w1c_set: got %h want %h", rd, 32'h08); end
        bus_write(A_PEND, 32'h08, 4'b1110);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h08) begin errors++; $display("FAIL w1c_masked: got %h want %h", rd, 32'h08); end
        bus_write(A_PEND, 32'h08, 4'b0001);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h want 0", rd); end
        // New rising edge lands on the same edge that commits the W1C.
        src_i = 8'h08;
        @(negedge clk);
        src_i = 8'h00;
        @(negedge clk);
        bus_write(A_PEND, 32'h08, 4'b0001);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h08) begin errors++; $display("FAIL w1c_race: got %h want %h", rd, 32'h08); end
        bus_write(A_PEND, 32'hFF, 4'b0001);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_final: got %h want 0", rd); end
        // Level mode ignores W1C.
        bus_write(A_EDGE, 32'h0, 4'b1111);
        src_i = 8'h10;
        repeat (4) @(negedge clk);
        bus_write(A_PEND, 32'h10, 4'b1111);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h10) begin errors++; $display("FAIL w1c_level: got %h want %h", rd, 32'h10); end
        src_i = 8'h00;
        repeat (4) @(negedge clk);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL level_follow: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_bus();
        test_edge_handshake();
        test_level_withdraw();
        test_reset_mid_req();
        test_priority();
        test_w1c_race();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller sitting directly upstream of the processor's interrupt inputs.
- Synchronises up to 32 external interrupt sources and latches them as pending.
- Selects one enabled pending source and runs the irq/eoi handshake on line 0 of the processor's interrupt vector.
- Exposes pending/enable/mode/active registers as a memory-mapped slave on the processor's sel/ack data bus.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32).
- SYNC_STAGES, 2, synchroniser flops per source (>=2).

Ports:
- clk  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- src_i  in  NUM_SRC  raw interrupt sources, asynchronous, active-high
- irq_o  out  32  to processor irq_i; only bit 0 is used, bits 31:1 tied 0
- eoi_i  in  32  from processor eoi_o; only bit 0 is used
- sel_i  in  1  bus select, held by master until ack
- addr_i  in  4  byte address within the block (word aligned, bits 1:0 ignored)
- we_i  in  1  write enable
- wr_mask_i  in  4  byte write mask
- data_i  in  32  write data
- data_o  out  32  read data, valid while ack_o=1
- ack_o  out  1  single-cycle transfer acknowledge

Behaviour:
- Reset: asynchronous, active-low; all state cleared while reset_ni=0.
  - Output reset values: irq_o=0, ack_o=0, data_o=0.
  - Register reset values: PENDING=0, ENABLE=0, EDGE=0, state=IDLE.
- Synchronisation:
  - Each src_i passes through SYNC_STAGES flops; s = synchronised value.
  - One further flop s_d is kept for edge detection.
- Pending (per source i):
  - EDGE[i]=1 (edge mode): rising edge (s & ~s_d) sets PENDING[i]. W1C write or service clears it. If a set and a clear hit the same cycle, set wins.
  - EDGE[i]=0 (level mode): PENDING[i] follows s every cycle; W1C has no effect.
- Register map (word offsets):
  - 0x0 PENDING: R; W1C, byte-masked.
  - 0x4 ENABLE: RW, byte-masked.
  - 0x8 EDGE: RW, byte-masked.
  - 0xC ACTIVE: R; bit31 = state!=IDLE, bits[4:0] = active id, others 0. Writes ignored.
  - Bits at index >= NUM_SRC read 0 and ignore writes.
- Bus protocol:
  - ack_o <= sel_i & ~ack_o, giving exactly one ack per request even if sel_i is still high on the cycle after ack.
  - Reads: data_o registered together with ack_o; data_o=0 when ack_o=0.
  - Writes: committed on the same edge that raises ack_o; latency is 1 cycle.
- Request FSM, states IDLE, REQ, SERVICE, GAP:
  - req_vec = PENDING & ENABLE.
  - IDLE: if req_vec != 0, latch id = selected index, go REQ, irq_o[0]=1 from the next cycle.
  - REQ: irq_o[0]=1.
    - If eoi_i[0]=0 (processor accepted), go SERVICE, drop irq_o[0], and clear PENDING[id] if EDGE[id]=1.
    - Else if req_vec[id]=0 (disabled or level dropped before acceptance), withdraw: irq_o[0]=0, go IDLE.
  - SERVICE: irq_o[0]=0; wait for eoi_i[0]=1, then go GAP.
  - GAP: one cycle with irq_o[0]=0, then IDLE. The processor needs a cycle to re-sample.
  - Re-triggers of id during SERVICE set pending normally and are delivered after GAP.
  - Bus accesses proceed in any state.
- Selection: lowest index of req_vec (fixed priority) unless the optional feature is enabled.

Optional Feature:
- Macro: IRQ_CTRL_ROUND_ROBIN_EN.
- Defined: a last_id register (reset 0) is updated on each SERVICE entry. Selection is the first set bit of req_vec searching upward from last_id+1, wrapping modulo NUM_SRC.
- Undefined: fixed lowest-index priority; last_id does not exist.

Test Plan:
- Reset and bus:
  - Assert reset_ni=0 mid-REQ -> irq_o=0, all registers 0, ACTIVE reads 0x00000000.
  - Write ENABLE=0xFF with wr_mask=0001 -> reads back 0x000000FF.
  - Hold sel_i 2 cycles -> exactly one ack_o pulse.
- Edge source, full handshake:
  - EDGE=0x04, ENABLE=0x04, pulse src_i[2] -> PENDING=0x04 after SYNC_STAGES+1 cycles, then irq_o[0]=1.
  - Drop eoi_i[0] -> irq_o[0]=0 next cycle and PENDING=0, ACTIVE=0x80000002.
  - Raise eoi_i[0] -> GAP then IDLE, ACTIVE=0.
- Level withdraw:
  - EDGE=0, ENABLE=0x01, src_i[0]=1 -> irq_o[0]=1.
  - Deassert src_i[0] before eoi -> irq_o[0]=0, return to IDLE, no SERVICE.
- Priority:
  - Sources 1 and 5 both pending, edge mode -> id 1 served first, then id 5 after GAP.
  - With IRQ_CTRL_ROUND_ROBIN_EN, after serving 5 with 1 and 6 both pending -> 6 served next.
- W1C race:
  - W1C of PENDING bit 3 on the same cycle as a new rising edge on src 3 -> PENDING[3] stays 1.
- Unmapped bits:
  - NUM_SRC=8, write 0xFFFFFFFF to ENABLE -> reads 0x000000FF.
